udp_event_timestamper: RTL and testbench



---
 rtl/udp_event_timestamper_if.sv | 26 ++
 rtl/udp_event_timestamper.sv | 96 +++++++++
 tb/tb_udp_event_timestamper.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/udp_event_timestamper_if.sv
// udp_event_timestamper_if: start/end strobes plus completed-record valid/ready stream.
//   slave  : timestamper side (consumes strobes, produces records)
//   master : environment side (issues strobes, consumes records)
interface udp_event_timestamper_if #(
  parameter int ID_W = 16,
  parameter int TS_W = 64
);
  logic            start_valid;
  logic [ID_W-1:0] start_id;
  logic            end_valid;
  logic [ID_W-1:0] end_id;
  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] out_id;
  logic [TS_W-1:0] out_start_ts;
  logic [TS_W-1:0] out_end_ts;
  logic [TS_W-1:0] out_delta;
  modport slave (
    input  start_valid, start_id, end_valid, end_id, out_ready,
    output out_valid, out_id, out_start_ts, out_end_ts, out_delta
  );
  modport master (
    output start_valid, start_id, end_valid, end_id, out_ready,
    input  out_valid, out_id, out_start_ts, out_end_ts, out_delta
  );
endinterface

// File: rtl/udp_event_timestamper.sv
// udp_event_timestamper: pairs start/end strobes by id, timestamps them and queues {id,start,end,delta} records.
//   clk, rst_n (async, active-low), ts_clear (sync counter clear)
//   bus        : strobes in, record stream out (udp_event_timestamper_if.slave)
//   drop_cnt   : completions lost to a full FIFO (saturating)
//   orphan_cnt : end strobes with no matching pending start (saturating)
//   ovwr_cnt   : starts that replaced a still-pending slot (saturating)
module udp_event_timestamper #(
  parameter int ID_W      = 16,
  parameter int TS_W      = 64,
  parameter int TAG_W     = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ts_clear,
  udp_event_timestamper_if.slave bus,
  output logic [15:0] drop_cnt,
  output logic [15:0] orphan_cnt,
  output logic [15:0] ovwr_cnt
);
  localparam int SLOTS = 1 << TAG_W;
  localparam int PW    = $clog2(OUT_DEPTH);
  localparam int REC_W = ID_W + 3 * TS_W;
  logic [TS_W-1:0]  ts;
  logic [SLOTS-1:0] slot_v;
  logic [ID_W-1:0]  slot_id [SLOTS];
  logic [TS_W-1:0]  slot_ts [SLOTS];
  logic [TAG_W-1:0] s_idx, e_idx;
  logic [TS_W-1:0]  e_start;
  logic             e_hit, e_miss, ovwr, push, pop, full, drop;
  logic [PW:0]      wr_ptr, rd_ptr, fill;
  logic [REC_W-1:0] mem [OUT_DEPTH];
  logic [REC_W-1:0] rec, head;
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
    return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction
  assign s_idx   = bus.start_id[TAG_W-1:0];
  assign e_idx   = bus.end_id[TAG_W-1:0];
  assign e_start = slot_ts[e_idx];
  // The end lookup always sees the pre-edge table, so a same-cycle start never masks a completion.
  assign e_hit   = bus.end_valid && slot_v[e_idx] && slot_id[e_idx] == bus.end_id;
  assign e_miss  = bus.end_valid && !e_hit;
  // A start landing on a slot that this cycle's end is retiring is not an overwrite.
  assign ovwr    = bus.start_valid && slot_v[s_idx] && !(e_hit && e_idx == s_idx);
  assign rec     = {bus.end_id, e_start, ts, ts - e_start};
  assign fill    = wr_ptr - rd_ptr;
  assign full    = fill == (PW+1)'(OUT_DEPTH);
  assign pop     = bus.out_valid && bus.out_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push    = e_hit && (!full || pop);
  assign drop    = e_hit && full && !pop;
  assign head    = mem[rd_ptr[PW-1:0]];
  assign bus.out_valid = fill != '0;
  assign {bus.out_id, bus.out_start_ts, bus.out_end_ts, bus.out_delta} = head;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ts <= '0;
    else ts <= ts_clear ? '0 : ts + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_v <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_id[i] <= '0;
        slot_ts[i] <= '0;
      end
    end else begin
      if (e_hit) slot_v[e_idx] <= 1'b0;
      if (bus.start_valid) begin
        slot_v[s_idx]  <= 1'b1;
        slot_id[s_idx] <= bus.start_id;
        slot_ts[s_idx] <= ts;
      end
    end
  // Storage is reset too so the head (and thus out_* data) reads zero after reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= rec;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      drop_cnt   <= '0;
      orphan_cnt <= '0;
      ovwr_cnt   <= '0;
    end else begin
      drop_cnt   <= sat_inc(drop_cnt, drop);
      orphan_cnt <= sat_inc(orphan_cnt, e_miss);
      ovwr_cnt   <= sat_inc(ovwr_cnt, ovwr);
    end
endmodule

// File: tb/tb_udp_event_timestamper.sv
// tb_udp_event_timestamper: directed self-checking bench for udp_event_timestamper (TS_W=8 to exercise wrap).
module tb_udp_event_timestamper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ts_clear = 1'b0;
  logic [15:0] drop_cnt, orphan_cnt, ovwr_cnt;
  int n_chk = 0;
  int n_bad = 0;
  int now = 0;
  udp_event_timestamper_if #(.ID_W(16), .TS_W(8)) bus ();
  udp_event_timestamper #(.ID_W(16), .TS_W(8), .TAG_W(4), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ts_clear(ts_clear), .bus(bus),
    .drop_cnt(drop_cnt), .orphan_cnt(orphan_cnt), .ovwr_cnt(ovwr_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // now = ts after the latest edge = the value a strobe driven now will capture
  task automatic step();
    @(posedge clk);
    #1;
    now = (now + 1) % 256;
  endtask
  task automatic clear_ts();
    ts_clear = 1'b1;
    step();
    ts_clear = 1'b0;
    now = 0;
  endtask
  task automatic go_to(input int t);
    while (now != t) step();
  endtask
  task automatic strobe(input logic sv, input logic [15:0] sid, input logic ev, input logic [15:0] eid);
    bus.start_valid = sv;
    bus.start_id = sid;
    bus.end_valid = ev;
    bus.end_id = eid;
    step();
    bus.start_valid = 1'b0;
    bus.end_valid = 1'b0;
  endtask
  task automatic chk_rec(input string tag, input int id, input int s, input int e, input int d);
    chk({tag, ".valid"}, bus.out_valid, 1);
    chk({tag, ".id"}, bus.out_id, id);
    chk({tag, ".start"}, bus.out_start_ts, s);
    chk({tag, ".end"}, bus.out_end_ts, e);
    chk({tag, ".delta"}, bus.out_delta, d);
  endtask
  initial begin
    bus.start_valid = 1'b0;
    bus.start_id = '0;
    bus.end_valid = 1'b0;
    bus.end_id = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", bus.out_valid, 0);
    chk("rst.id", bus.out_id, 0);
    chk("rst.delta", bus.out_delta, 0);
    chk("rst.cnts", {drop_cnt, orphan_cnt, ovwr_cnt}, 0);
    rst_n = 1'b1;
    clear_ts();
    // basic completion
    go_to(10);
    strobe(1, 16'h0005, 0, 0);
    go_to(25);
    strobe(0, 0, 1, 16'h0005);
    chk_rec("basic", 5, 10, 25, 15);
    step();
    chk("basic.one_cycle", bus.out_valid, 0);
    chk("basic.cnts", {drop_cnt, orphan_cnt, ovwr_cnt}, 0);
    // orphan: same slot, different full id
    go_to(30);
    strobe(1, 16'h0005, 0, 0);
    strobe(0, 0, 1, 16'h0015);
    chk("orphan.cnt", orphan_cnt, 1);
    chk("orphan.norec", bus.out_valid, 0);
    strobe(0, 0, 1, 16'h0005);
    chk_rec("orphan.later", 5, 30, 32, 2);
    step();
    // backpressure: 6 completions into a 4-deep FIFO
    bus.out_ready = 1'b0;
    go_to(50);
    for (int i = 0; i < 6; i++) strobe(1, 16'h0030 + 16'(i), 0, 0);
    go_to(60);
    for (int i = 0; i < 6; i++) strobe(0, 0, 1, 16'h0030 + 16'(i));
    chk("bp.drop", drop_cnt, 2);
    chk("bp.head", bus.out_id, 16'h0030);
    step();
    chk("bp.hold", bus.out_id, 16'h0030);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_rec("bp.drain", 16'h0030 + k, 50 + k, 60 + k, 10);
      step();
    end
    chk("bp.empty", bus.out_valid, 0);
    // same-cycle start and end on one slot
    go_to(100);
    strobe(1, 16'h0003, 0, 0);
    go_to(140);
    strobe(1, 16'h0003, 1, 16'h0003);
    chk_rec("same", 3, 100, 140, 40);
    chk("same.ovwr", ovwr_cnt, 0);
    step();
    go_to(150);
    strobe(0, 0, 1, 16'h0003);
    chk_rec("same.repend", 3, 140, 150, 10);
    step();
    strobe(1, 16'h0007, 0, 0);
    strobe(1, 16'h0007, 0, 0);
    chk("ovwr.cnt", ovwr_cnt, 1);
    // timestamp wrap
    go_to(250);
    strobe(1, 16'h0009, 0, 0);
    go_to(4);
    strobe(0, 0, 1, 16'h0009);
    chk_rec("wrap", 9, 250, 4, 10);
    step();
    // reset mid-operation
    bus.out_ready = 1'b0;
    strobe(1, 16'h0041, 0, 0);
    strobe(1, 16'h0042, 0, 0);
    strobe(0, 0, 1, 16'h0041);
    strobe(0, 0, 1, 16'h0042);
    strobe(1, 16'h0044, 0, 0);
    strobe(1, 16'h0045, 0, 0);
    strobe(1, 16'h0046, 0, 0);
    chk("pre.valid", bus.out_valid, 1);
    chk("pre.cnts", {drop_cnt, orphan_cnt, ovwr_cnt}, {16'd2, 16'd1, 16'd1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", bus.out_valid, 0);
    chk("arst.id", bus.out_id, 0);
    chk("arst.start", bus.out_start_ts, 0);
    chk("arst.cnts", {drop_cnt, orphan_cnt, ovwr_cnt}, 0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    clear_ts();
    strobe(0, 0, 1, 16'h0044);
    chk("post.orphan", orphan_cnt, 1);
    chk("post.norec", bus.out_valid, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
